// File: rtl/vector_issue_sequencer_if.sv
// Decode/register-file side bundle of the vector issue sequencer; the sequencer is the slave.
// Combinational only; stall is the backpressure input and freezes the slave for that cycle.
interface vector_issue_sequencer_if;
    logic       start;
    logic [5:0] vl;
    logic [1:0] vsew;
    logic       widening_op;
    logic       reads_vd;
    logic [4:0] vs1_base;
    logic [4:0] vs2_base;
    logic [4:0] vd_base;
    logic       stall;
    logic [4:0] rf_vs1_addr;
    logic [4:0] rf_vs2_addr;
    logic [4:0] rf_vd_addr;
    logic [1:0] rf_elements_to_write;
    logic       rf_write;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, vl, vsew, widening_op, reads_vd, vs1_base, vs2_base, vd_base, stall,
        input  rf_vs1_addr, rf_vs2_addr, rf_vd_addr, rf_elements_to_write, rf_write,
               busy, done, error
    );

    modport slave (
        input  start, vl, vsew, widening_op, reads_vd, vs1_base, vs2_base, vd_base, stall,
        output rf_vs1_addr, rf_vs2_addr, rf_vd_addr, rf_elements_to_write, rf_write,
               busy, done, error
    );
endinterface

// File: rtl/vector_issue_sequencer.sv
// Walks one vector instruction over the register file, one 4-element group per cycle; writes land
// PE_LATENCY active cycles after issue. stall freezes all state and masks rf_write for that cycle.
module vector_issue_sequencer #(
    parameter int PE_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    vector_issue_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] vd;
        logic [1:0] cnt;
    } wr_ent_t;

    state_t     state;
    logic       reads_vd_q;
    logic [1:0] tail_cnt;
    logic [2:0] grp;
    logic [2:0] last_grp;
    logic [4:0] vs1_q;
    logic [4:0] vs2_q;
    logic [4:0] vd_q;
    logic [4:0] src_step;
    logic [4:0] dst_step;
    logic       done_q;
    logic       error_q;
    wr_ent_t    dl [PE_LATENCY];

    logic       reject;
    logic       early_busy;
    logic       issue_en;
    wr_ent_t    iss_ent;

    assign reject = (bus.vsew == 2'd3) || (bus.widening_op && (bus.vsew == 2'd2)) ||
                    (bus.vl > 6'd32);

    // Everything except the head stage; empty means the head is the final pending write.
    always_comb begin
        early_busy = 1'b0;
        for (int i = 0; i < PE_LATENCY - 1; i++) begin
            early_busy = early_busy | dl[i].vld;
        end
    end

    // Serial mode waits for the previous group's write so vs3 reads never meet a write.
    assign issue_en = (state == ISSUE) && !bus.stall &&
                      (!reads_vd_q || !(early_busy || dl[PE_LATENCY-1].vld));

    always_comb begin
        iss_ent = '0;
        if (issue_en) begin
            iss_ent.vld = 1'b1;
            iss_ent.vd  = vd_q;
            iss_ent.cnt = (grp == last_grp) ? tail_cnt : 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            reads_vd_q <= 1'b0;
            tail_cnt   <= 2'd0;
            grp        <= 3'd0;
            last_grp   <= 3'd0;
            vs1_q      <= 5'd0;
            vs2_q      <= 5'd0;
            vd_q       <= 5'd0;
            src_step   <= 5'd0;
            dst_step   <= 5'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            for (int i = 0; i < PE_LATENCY; i++) begin
                dl[i] <= '0;
            end
        end else if (!bus.stall) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            dl[0]   <= iss_ent;
            for (int i = 1; i < PE_LATENCY; i++) begin
                dl[i] <= dl[i-1];
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (reject) begin
                            error_q <= 1'b1;
                        end else if (bus.vl == 6'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            reads_vd_q <= bus.reads_vd;
                            tail_cnt   <= bus.vl[1:0];
                            grp        <= 3'd0;
                            last_grp   <= 3'((bus.vl - 6'd1) >> 2);
                            vs1_q      <= bus.vs1_base;
                            vs2_q      <= bus.vs2_base;
                            vd_q       <= bus.vd_base;
                            src_step   <= 5'd1 << bus.vsew;
                            dst_step   <= 5'd1 << ({1'b0, bus.vsew} + {2'b00, bus.widening_op});
                        end
                    end
                end
                ISSUE: begin
                    if (issue_en) begin
                        if (grp == last_grp) begin
                            state <= DRAIN;
                        end else begin
                            grp   <= grp + 3'd1;
                            vs1_q <= vs1_q + src_step;
                            vs2_q <= vs2_q + src_step;
                            vd_q  <= vd_q + dst_step;
                        end
                    end
                end
                DRAIN: begin
                    if (!early_busy) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rf_write             = dl[PE_LATENCY-1].vld && !bus.stall;
    assign bus.rf_vd_addr           = bus.rf_write ? dl[PE_LATENCY-1].vd : vd_q;
    assign bus.rf_elements_to_write = dl[PE_LATENCY-1].cnt;
    assign bus.rf_vs1_addr          = vs1_q;
    assign bus.rf_vs2_addr          = vs2_q;
    assign bus.busy                 = (state != IDLE);
    assign bus.done                 = done_q;
    assign bus.error                = error_q;
endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Randomized bench for vector_issue_sequencer: an issue/write schedule per instruction is
// computed from group timing rules and compared cycle by cycle against the DUT.
module tb_vector_issue_sequencer;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    vector_issue_sequencer_if bus();

    vector_issue_sequencer #(.PE_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.vl          = 6'd0;
        bus.vsew        = 2'd0;
        bus.widening_op = 1'b0;
        bus.reads_vd    = 1'b0;
        bus.vs1_base    = 5'd0;
        bus.vs2_base    = 5'd0;
        bus.vd_base     = 5'd0;
        bus.stall       = 1'b0;
    endtask

    task automatic noise_inputs();
        bus.start       = 1'($urandom_range(0, 1));
        bus.vl          = 6'($urandom_range(0, 63));
        bus.vsew        = 2'($urandom_range(0, 3));
        bus.widening_op = 1'($urandom_range(0, 1));
        bus.reads_vd    = 1'($urandom_range(0, 1));
        bus.vs1_base    = 5'($urandom_range(0, 31));
        bus.vs2_base    = 5'($urandom_range(0, 31));
        bus.vd_base     = 5'($urandom_range(0, 31));
    endtask

    // Legal instruction with vl>0; fixed_at>=0 forces a 3-cycle stall at that active index.
    task automatic run_instr(input int vl, input int vsew, input int wid, input int rvd,
                             input int b1, input int b2, input int bd,
                             input int stall_pct, input int fixed_at);
        int  s_step, d_step, n_grp, last_w, a, cyc, fixed_left, wg, ig;
        int  iss_t [8];
        int  wr_t  [8];
        bit  st;
        s_step = 1 << vsew;
        d_step = 1 << (vsew + wid);
        n_grp  = (vl + 3) / 4;
        for (int g = 0; g < n_grp; g++) begin
            iss_t[g] = (rvd != 0) ? g * (LAT + 1) : g;
            wr_t[g]  = iss_t[g] + LAT;
        end
        last_w = wr_t[n_grp-1];

        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.vl          = 6'(vl);
        bus.vsew        = 2'(vsew);
        bus.widening_op = 1'(wid);
        bus.reads_vd    = 1'(rvd);
        bus.vs1_base    = 5'(b1);
        bus.vs2_base    = 5'(b2);
        bus.vd_base     = 5'(bd);
        bus.stall       = 1'b0;
        @(posedge clk); #1;

        a = 0;
        cyc = 0;
        fixed_left = 3;
        while (a <= last_w && cyc < 400) begin
            st = 1'b0;
            if (fixed_at >= 0 && a == fixed_at && fixed_left > 0) begin
                st = 1'b1;
                fixed_left--;
            end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                st = 1'b1;
            end
            noise_inputs();
            bus.stall = st;
            @(negedge clk);
            check("busy_during", bus.busy, 1);
            check("done_early", bus.done, 0);
            if (st) begin
                check("wr_in_stall", bus.rf_write, 0);
            end else begin
                wg = -1;
                ig = -1;
                for (int g = 0; g < n_grp; g++) begin
                    if (wr_t[g] == a) wg = g;
                    if (iss_t[g] == a) ig = g;
                end
                check("rf_write", bus.rf_write, (wg >= 0) ? 1 : 0);
                if (wg >= 0) begin
                    check("wr_vd", bus.rf_vd_addr, (bd + wg * d_step) % 32);
                    check("wr_cnt", bus.rf_elements_to_write, (wg == n_grp - 1) ? vl % 4 : 0);
                end
                if (ig >= 0) begin
                    check("iss_vs1", bus.rf_vs1_addr, (b1 + ig * s_step) % 32);
                    check("iss_vs2", bus.rf_vs2_addr, (b2 + ig * s_step) % 32);
                    if (wg < 0) check("iss_vd", bus.rf_vd_addr, (bd + ig * d_step) % 32);
                end
                a++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        if (cyc >= 400) check("timeout", 1, 0);

        idle_inputs();
        @(negedge clk);
        check("done_pulse", bus.done, 1);
        check("busy_at_done", bus.busy, 0);
        check("wr_at_done", bus.rf_write, 0);
        check("err_at_done", bus.error, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_width", bus.done, 0);
    endtask

    // vl=0 or rejected start: single pulse, never leaves IDLE.
    task automatic run_short(input int vl, input int vsew, input int wid, input bit exp_err);
        @(posedge clk); #1;
        idle_inputs();
        bus.start       = 1'b1;
        bus.vl          = 6'(vl);
        bus.vsew        = 2'(vsew);
        bus.widening_op = 1'(wid);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("short_err", bus.error, exp_err ? 1 : 0);
        check("short_done", bus.done, exp_err ? 0 : 1);
        check("short_busy", bus.busy, 0);
        check("short_wr", bus.rf_write, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("short_err2", bus.error, 0);
        check("short_done2", bus.done, 0);
        check("short_busy2", bus.busy, 0);
    endtask

    task automatic run_stalled_start();
        @(posedge clk); #1;
        idle_inputs();
        bus.start = 1'b1;
        bus.vl    = 6'd8;
        bus.stall = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("stall_start_busy", bus.busy, 0);
        check("stall_start_done", bus.done, 0);
        check("stall_start_err", bus.error, 0);
    endtask

    task automatic run_reset_in_drain();
        @(posedge clk); #1;
        idle_inputs();
        bus.start = 1'b1;
        bus.vl    = 6'd4;
        bus.vd_base = 5'd9;
        bus.vs1_base = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_wr", bus.rf_write, 0);
        #1;
        reset = 1'b1;
        #1;
        check("rst_wr", bus.rf_write, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_vd", bus.rf_vd_addr, 0);
        check("rst_vs1", bus.rf_vs1_addr, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_wr", bus.rf_write, 0);
            check("post_rst_busy", bus.busy, 0);
            check("post_rst_done", bus.done, 0);
        end
    endtask

    initial begin
        int vsew, wid;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state_busy", bus.busy, 0);
        check("rst_state_done", bus.done, 0);
        check("rst_state_err", bus.error, 0);
        check("rst_state_wr", bus.rf_write, 0);
        check("rst_state_vs1", bus.rf_vs1_addr, 0);
        check("rst_state_vs2", bus.rf_vs2_addr, 0);
        check("rst_state_vd", bus.rf_vd_addr, 0);
        check("rst_state_cnt", bus.rf_elements_to_write, 0);
        reset = 1'b0;

        run_instr(10, 0, 0, 0, 8, 16, 24, 0, -1);
        run_instr(8, 1, 1, 0, 3, 5, 4, 0, -1);
        run_instr(5, 2, 0, 1, 1, 2, 7, 0, -1);
        run_instr(16, 0, 0, 0, 1, 2, 3, 0, 2);
        run_instr(32, 2, 0, 0, 30, 28, 31, 0, -1);
        run_instr(32, 1, 1, 1, 17, 0, 20, 20, -1);
        run_short(0, 0, 0, 1'b0);
        run_short(5, 2, 1, 1'b1);
        run_short(4, 3, 0, 1'b1);
        run_short(33, 0, 0, 1'b1);
        run_short(0, 3, 0, 1'b1);
        run_stalled_start();

        for (int n = 0; n < 40; n++) begin
            vsew = $urandom_range(0, 2);
            wid  = (vsew < 2) ? $urandom_range(0, 1) : 0;
            run_instr($urandom_range(1, 32), vsew, wid, $urandom_range(0, 1),
                      $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 3) * 10, -1);
            if ($urandom_range(0, 3) == 0) run_short($urandom_range(33, 63), vsew, wid, 1'b1);
        end

        run_reset_in_drain();
        run_instr(7, 0, 1, 0, 2, 4, 6, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
